// File: rtl/sgbus_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgbus_frame_pkg
//  Purpose  : SGBUS frame format definitions shared by the RX deframer and
//             the TX framer: header/trailer layouts, sync words, beat limits
//             and the checksum fold.
//  Revision : 1.0  initial release
// ============================================================================
package sgbus_frame_pkg;

    localparam int          PAYLOAD_WIDTH = 128;
    localparam logic [15:0] HDR_SYNC      = 16'hA55A;
    localparam logic [15:0] TLR_SYNC      = 16'h5AA5;
    localparam int          MAX_BEATS     = 256;
    // Wide enough to hold a beat count of MAX_BEATS itself.
    localparam int          REM_WIDTH     = $clog2(MAX_BEATS + 1);

    // Header beat layout, MSB first.
    typedef struct packed {
        logic [15:0] sync;
        logic [7:0]  dest;
        logic [7:0]  rsvd0;
        logic [15:0] len;
        logic [15:0] seq;
        logic [63:0] rsvd1;
    } sgbus_hdr_t;

    // Trailer beat layout, MSB first.
    typedef struct packed {
        logic [15:0] sync;
        logic [47:0] rsvd;
        logic [63:0] csum;
    } sgbus_tlr_t;

    // Deframer states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } deframer_state_t;

    // Per-beat contribution to the frame checksum.
    function automatic logic [63:0] sgbus_csum_fold(input logic [PAYLOAD_WIDTH-1:0] beat);
        return beat[127:64] ^ beat[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sgbus_rx_deframer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sgbus_rx_deframer_if
//  Purpose  : AXI-Stream style beat channel used on both sides of the
//             deframer (upstream SGBUS stream and downstream payload).
//  Revision : 1.0  initial release
// ============================================================================
interface sgbus_rx_deframer_if;
    import sgbus_frame_pkg::*;

    logic [PAYLOAD_WIDTH-1:0] tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [7:0]               tdest;
    logic                     tuser;

    modport master (
        output tdata, tvalid, tlast, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tdest, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/sgbus_deframer_outreg.sv
`default_nettype none
// ============================================================================
//  Module   : sgbus_deframer_outreg
//  Purpose  : One-deep output register for the deframer. Non-last beats are
//             presented immediately; the last beat is parked (pend) until
//             the trailer decides its error flag, then released with tlast.
//  Revision : 1.0  initial release
// ============================================================================
module sgbus_deframer_outreg
    import sgbus_frame_pkg::*;
(
    input  wire logic                     clk,
    input  wire logic                     reset_n,
    input  wire logic                     i_load_beat,
    input  wire logic                     i_load_pend,
    input  wire logic                     i_release,
    input  wire logic                     i_err,
    input  wire logic [PAYLOAD_WIDTH-1:0] i_data,
    input  wire logic [7:0]               i_dest,
    sgbus_rx_deframer_if.master           m_axis
);

    logic                     valid_q, valid_d;
    logic                     pend_q,  pend_d;
    logic                     last_q,  last_d;
    logic                     user_q,  user_d;
    logic [PAYLOAD_WIDTH-1:0] data_q,  data_d;
    logic [7:0]               dest_q,  dest_d;

    // Next-state for the output slot: drain on handshake, then apply load/release.
    always_comb begin
        valid_d = valid_q;
        pend_d  = pend_q;
        last_d  = last_q;
        user_d  = user_q;
        data_d  = data_q;
        dest_d  = dest_q;

        if (valid_q && m_axis.tready) begin
            valid_d = 1'b0;
        end

        if (i_load_beat) begin
            valid_d = 1'b1;
            last_d  = 1'b0;
            user_d  = 1'b0;
            data_d  = i_data;
            dest_d  = i_dest;
        end else if (i_load_pend) begin
            // Last beat is held invisible until the trailer verdict is known.
            valid_d = 1'b0;
            pend_d  = 1'b1;
            last_d  = 1'b0;
            user_d  = 1'b0;
            data_d  = i_data;
            dest_d  = i_dest;
        end else if (i_release && pend_q) begin
            valid_d = 1'b1;
            pend_d  = 1'b0;
            last_d  = 1'b1;
            user_d  = i_err;
        end
    end

    // Output slot flops; tdest travels with the beat so it stays stable
    // even when the next header is accepted while this beat is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            data_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            user_q  <= user_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = last_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tdest  = dest_q;

endmodule
`default_nettype wire

// File: rtl/sgbus_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : sgbus_rx_deframer
//  Purpose  : Hunts SGBUS frame headers in the continuous RX payload stream,
//             forwards payload beats as AXI-Stream with tlast/tdest/tuser,
//             verifies the trailer checksum and keeps status counters.
//  Revision : 1.0  initial release
// ============================================================================
module sgbus_rx_deframer
    import sgbus_frame_pkg::*;
#(
    parameter int CNT_WIDTH = 32
)(
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    sgbus_rx_deframer_if.slave        s_axis,
    sgbus_rx_deframer_if.master       m_axis,
    output logic [CNT_WIDTH-1:0]      frame_ok_cnt,
    output logic [CNT_WIDTH-1:0]      frame_err_cnt,
    output logic [CNT_WIDTH-1:0]      sync_err_cnt,
    output logic                      in_frame
);

    deframer_state_t        state_q,       state_d;
    logic [REM_WIDTH-1:0]   remaining_q,   remaining_d;
    logic [63:0]            acc_q,         acc_d;
    logic [7:0]             dest_q,        dest_d;
    logic [15:0]            exp_seq_q,     exp_seq_d;
    logic                   seq_err_q,     seq_err_d;
    logic [CNT_WIDTH-1:0]   frame_ok_q,    frame_ok_d;
    logic [CNT_WIDTH-1:0]   frame_err_q,   frame_err_d;
    logic [CNT_WIDTH-1:0]   sync_err_q,    sync_err_d;

    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_len_ok;
    logic                   w_load_beat;
    logic                   w_load_pend;
    logic                   w_release;
    logic                   w_tlr_err;
    sgbus_hdr_t             w_hdr;
    sgbus_tlr_t             w_tlr;
    logic                   unused_sideband;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_hdr    = sgbus_hdr_t'(s_axis.tdata);
    assign w_tlr    = sgbus_tlr_t'(s_axis.tdata);
    assign w_accept = s_axis.tvalid && w_s_ready;
    assign w_len_ok = (w_hdr.len >= 16'd1) && (w_hdr.len <= 16'(MAX_BEATS));

    // Upstream has no sideband, and reserved header/trailer fields are don't-care.
    assign unused_sideband = ^{s_axis.tlast, s_axis.tdest, s_axis.tuser,
                               w_hdr.rsvd0, w_hdr.rsvd1, w_tlr.rsvd};

    // Only payload beats need a free output slot; HUNT and TRAILER always consume.
    always_comb begin
        w_s_ready = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            w_s_ready = !m_axis.tvalid || m_axis.tready;
        end
    end

    assign s_axis.tready = w_s_ready;

    // Frame state machine, checksum accumulation and counter updates.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        dest_d      = dest_q;
        exp_seq_d   = exp_seq_q;
        seq_err_d   = seq_err_q;
        frame_ok_d  = frame_ok_q;
        frame_err_d = frame_err_q;
        sync_err_d  = sync_err_q;
        w_load_beat = 1'b0;
        w_load_pend = 1'b0;
        w_release   = 1'b0;
        w_tlr_err   = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (w_accept && (w_hdr.sync == HDR_SYNC)) begin
                    if (w_len_ok) begin
                        dest_d      = w_hdr.dest;
                        remaining_d = w_hdr.len[REM_WIDTH-1:0];
                        acc_d       = '0;
                        seq_err_d   = (w_hdr.seq != exp_seq_q);
                        // Resync to the received number whether or not it matched.
                        exp_seq_d   = w_hdr.seq + 16'd1;
                        state_d     = ST_PAYLOAD;
                    end else begin
                        sync_err_d  = sat_inc(sync_err_q);
                    end
                end
            end

            ST_PAYLOAD: begin
                if (w_accept) begin
                    acc_d       = acc_q ^ sgbus_csum_fold(s_axis.tdata);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == REM_WIDTH'(1)) begin
                        w_load_pend = 1'b1;
                        state_d     = ST_TRAILER;
                    end else begin
                        w_load_beat = 1'b1;
                    end
                end
            end

            ST_TRAILER: begin
                if (w_accept) begin
                    w_tlr_err = (w_tlr.sync != TLR_SYNC) || (w_tlr.csum != acc_q) || seq_err_q;
                    w_release = 1'b1;
                    if (w_tlr_err) begin
                        frame_err_d = sat_inc(frame_err_q);
                    end else begin
                        frame_ok_d  = sat_inc(frame_ok_q);
                    end
                    if (w_tlr.sync != TLR_SYNC) begin
                        sync_err_d  = sat_inc(sync_err_q);
                    end
                    state_d = ST_HUNT;
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Control and status flops; a reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            remaining_q <= '0;
            acc_q       <= '0;
            dest_q      <= '0;
            exp_seq_q   <= '0;
            seq_err_q   <= 1'b0;
            frame_ok_q  <= '0;
            frame_err_q <= '0;
            sync_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            dest_q      <= dest_d;
            exp_seq_q   <= exp_seq_d;
            seq_err_q   <= seq_err_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            sync_err_q  <= sync_err_d;
        end
    end

    sgbus_deframer_outreg u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load_beat (w_load_beat),
        .i_load_pend (w_load_pend),
        .i_release   (w_release),
        .i_err       (w_tlr_err),
        .i_data      (s_axis.tdata),
        .i_dest      (dest_q),
        .m_axis      (m_axis)
    );

    assign frame_ok_cnt  = frame_ok_q;
    assign frame_err_cnt = frame_err_q;
    assign sync_err_cnt  = sync_err_q;
    assign in_frame      = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_sgbus_rx_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sgbus_rx_deframer
//  Purpose  : Self-checking bench for sgbus_rx_deframer. Frames are built
//             from the frame-format rules; expected payload beats, flags and
//             counters come from a frame-level model, with literal pins on
//             hand-computed frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sgbus_rx_deframer;
    import sgbus_frame_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sgbus_rx_deframer_if s_if ();
    sgbus_rx_deframer_if m_if ();

    logic [31:0] frame_ok_cnt, frame_err_cnt, sync_err_cnt;
    logic        in_frame;

    sgbus_rx_deframer #(.CNT_WIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .sync_err_cnt  (sync_err_cnt),
        .in_frame      (in_frame)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic         user;
        logic [7:0]   dest;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_seen = 0;
    int          exp_ok = 0, exp_err = 0, exp_sync = 0;
    logic [15:0] model_seq = 16'd0;
    logic [3:0]  rdy_pat = 4'b1111;
    int          rdy_idx = 0;
    logic        stalled = 1'b0;
    logic [127:0] held;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] d, input logic last, input logic user, input logic [7:0] dest);
        exp_t x;
        x.data = d; x.last = last; x.user = user; x.dest = dest;
        exp_q.push_back(x);
    endtask

    // Present one upstream beat and hold it until the DUT takes it.
    task automatic drive_beat(input logic [127:0] d);
        bit done = 0;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_if.tready) begin
                done = 1;
                break;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++; n_errors++;
            $display("FAIL drive_timeout: beat %h not accepted", d);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_ok_cnt"},   frame_ok_cnt,  128'(exp_ok));
        chk({tag, "_err_cnt"},  frame_err_cnt, 128'(exp_err));
        chk({tag, "_sync_cnt"}, sync_err_cnt,  128'(exp_sync));
        chk({tag, "_in_frame"}, in_frame,      128'd0);
    endtask

    // Frame with random payload; verdict derived from the frame rules.
    task automatic send_frame(input logic [7:0] dest, input logic [15:0] len, input logic [15:0] seq,
                              input bit flip_csum, input bit bad_tsync);
        logic [63:0]  cs;
        logic [127:0] b;
        bit           err;
        cs  = 64'd0;
        err = flip_csum || bad_tsync || (seq != model_seq);
        model_seq = seq + 16'd1;
        drive_beat({HDR_SYNC, dest, 8'h00, len, seq, 64'h0});
        for (int i = 0; i < int'(len); i++) begin
            b  = {$urandom, $urandom, $urandom, $urandom};
            cs = cs ^ b[127:64] ^ b[63:0];
            push_exp(b, (i == int'(len) - 1), err, dest);
            drive_beat(b);
        end
        drive_beat({(bad_tsync ? 16'h0000 : TLR_SYNC), 48'h0, cs ^ {63'd0, flip_csum}});
        if (err) exp_err++; else exp_ok++;
        if (bad_tsync) exp_sync++;
    endtask

    // Hand-computed frame: beats {1,2},{4,8},{10,20}; fold XOR = 64'h3F.
    task automatic hand_frame(input logic [15:0] seq, input logic [63:0] csum, input logic user);
        model_seq = seq + 16'd1;
        push_exp({64'h1,  64'h2},  1'b0, 1'b0, 8'h03);
        push_exp({64'h4,  64'h8},  1'b0, 1'b0, 8'h03);
        push_exp({64'h10, 64'h20}, 1'b1, user, 8'h03);
        drive_beat({HDR_SYNC, 8'h03, 8'h00, 16'd3, seq, 64'h0});
        drive_beat({64'h1,  64'h2});
        drive_beat({64'h4,  64'h8});
        drive_beat({64'h10, 64'h20});
        drive_beat({TLR_SYNC, 48'h0, csum});
    endtask

    // Downstream ready follows a 4-cycle pattern.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = rdy_pat[rdy_idx % 4];
            rdy_idx++;
        end
    end

    // Output checker: every handshake against the model queue, AXIS hold rule,
    // and upstream back-pressure while the output slot is stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", m_if.tvalid, 128'd1);
                chk("hold_data",  m_if.tdata,  held);
            end
            if (in_frame && m_if.tvalid && !m_if.tready) begin
                chk("s_ready_in_stall", s_if.tready, 128'd0);
                stall_seen++;
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_beat: got %h expected none", m_if.tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", m_if.tdata, e.data);
                    chk("out_last", m_if.tlast, 128'(e.last));
                    chk("out_dest", m_if.tdest, 128'(e.dest));
                    if (e.last) chk("out_user", m_if.tuser, 128'(e.user));
                end
            end
            stalled = m_if.tvalid && !m_if.tready;
            held    = m_if.tdata;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tdata = '0; s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0; s_if.tdest = 8'h0; s_if.tuser = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid",   m_if.tvalid,   128'd0);
        chk("rst_tlast",    m_if.tlast,    128'd0);
        chk("rst_tuser",    m_if.tuser,    128'd0);
        chk("rst_tdest",    m_if.tdest,    128'd0);
        chk("rst_tdata",    m_if.tdata,    128'd0);
        chk("rst_s_tready", s_if.tready,   128'd1);
        chk("rst_ok_cnt",   frame_ok_cnt,  128'd0);
        chk("rst_in_frame", in_frame,      128'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: clean hand-computed frame
        hand_frame(16'd0, 64'h3F, 1'b0);
        exp_ok++;
        wait_drain("t1_drain");
        chk("t1_ok_literal", frame_ok_cnt, 128'd1);
        check_counters("t1");

        // 2: same frame, checksum bit 0 flipped
        hand_frame(16'd1, 64'h3E, 1'b1);
        exp_err++;
        wait_drain("t2_drain");
        chk("t2_err_literal", frame_err_cnt, 128'd1);
        check_counters("t2");

        // 3: garbage is dropped silently; boundary lengths 1 and MAX_BEATS
        repeat (5) drive_beat(128'h1234);
        send_frame(8'h07, 16'd2, model_seq, 0, 0);
        send_frame(8'h08, 16'd1, model_seq, 0, 0);
        send_frame(8'h09, 16'(MAX_BEATS), model_seq, 0, 0);
        wait_drain("t3_drain");
        chk("t3_sync_literal", sync_err_cnt, 128'd0);
        check_counters("t3");

        // 4: out-of-range lengths rejected, then lost trailer sync
        drive_beat({HDR_SYNC, 8'h0A, 8'h00, 16'd0,   model_seq, 64'h0});
        drive_beat({HDR_SYNC, 8'h0B, 8'h00, 16'd300, model_seq, 64'h0});
        drive_beat({HDR_SYNC, 8'h0C, 8'h00, 16'd257, model_seq, 64'h0});
        exp_sync += 3;
        repeat (3) @(posedge clk); #1;
        chk("t4_sync_literal", sync_err_cnt, 128'd3);
        check_counters("t4a");
        send_frame(8'h0D, 16'd2, model_seq, 0, 1);
        wait_drain("t4_drain");
        check_counters("t4b");

        // 5: downstream stalls 1,0,0,1; back-to-back frames with tlast stalled
        rdy_pat = 4'b1001;
        stall_seen = 0;
        send_frame(8'h55, 16'd4, model_seq, 0, 0);
        send_frame(8'h66, 16'd1, model_seq, 0, 0);
        send_frame(8'h77, 16'd3, model_seq, 0, 0);
        wait_drain("t5_drain");
        chk("t5_stall_observed", 128'(stall_seen > 0), 128'd1);
        rdy_pat = 4'b1111;
        repeat (4) @(posedge clk); #1;
        check_counters("t5");

        // Reset mid-frame: partial frame abandoned, everything cleared at once
        push_exp(128'hAAAA_0001, 1'b0, 1'b0, 8'h21);
        push_exp(128'hAAAA_0002, 1'b0, 1'b0, 8'h21);
        drive_beat({HDR_SYNC, 8'h21, 8'h00, 16'd5, model_seq, 64'h0});
        drive_beat(128'hAAAA_0001);
        drive_beat(128'hAAAA_0002);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_frame", in_frame,     128'd0);
        chk("mid_rst_tvalid",   m_if.tvalid,  128'd0);
        chk("mid_rst_s_tready", s_if.tready,  128'd1);
        chk("mid_rst_ok_cnt",   frame_ok_cnt, 128'd0);
        chk("mid_rst_sync_cnt", sync_err_cnt, 128'd0);
        chk("mid_rst_drained",  128'(exp_q.size()), 128'd0);
        exp_q.delete();
        exp_ok = 0; exp_err = 0; exp_sync = 0; model_seq = 16'd0;
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 6: sequence 0, 2 (gap -> error), 3 (resynced -> clean)
        send_frame(8'h31, 16'd2, 16'd0, 0, 0);
        send_frame(8'h32, 16'd2, 16'd2, 0, 0);
        send_frame(8'h33, 16'd2, 16'd3, 0, 0);
        wait_drain("t6_drain");
        chk("t6_ok_literal",  frame_ok_cnt,  128'd2);
        chk("t6_err_literal", frame_err_cnt, 128'd1);
        check_counters("t6");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
